// File: rtl/adder_ctrl_slave.sv
// AXI4-Lite control slave for the adder accelerator: block-level start/done/idle/ready
// handshake, two byte-strobed operand registers and one captured result register.
module adder_ctrl_slave #(
  parameter int unsigned AXI_ADDR_BITS = 6,
  parameter int unsigned AXI_DATA_BITS = 32,
  parameter int unsigned AXI_STRB_BITS = AXI_DATA_BITS / 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     s_axi_control_AWVALID,
  output logic                     s_axi_control_AWREADY,
  input  logic [AXI_ADDR_BITS-1:0] s_axi_control_AWADDR,
  input  logic                     s_axi_control_WVALID,
  output logic                     s_axi_control_WREADY,
  input  logic [AXI_DATA_BITS-1:0] s_axi_control_WDATA,
  input  logic [AXI_STRB_BITS-1:0] s_axi_control_WSTRB,
  output logic                     s_axi_control_BVALID,
  input  logic                     s_axi_control_BREADY,
  output logic [1:0]               s_axi_control_BRESP,
  input  logic                     s_axi_control_ARVALID,
  output logic                     s_axi_control_ARREADY,
  input  logic [AXI_ADDR_BITS-1:0] s_axi_control_ARADDR,
  output logic                     s_axi_control_RVALID,
  input  logic                     s_axi_control_RREADY,
  output logic [AXI_DATA_BITS-1:0] s_axi_control_RDATA,
  output logic [1:0]               s_axi_control_RRESP,
  output logic                     ap_start,
  input  logic                     ap_ready,
  input  logic                     ap_done,
  input  logic                     ap_idle,
  output logic [AXI_DATA_BITS-1:0] arg_a,
  output logic [AXI_DATA_BITS-1:0] arg_b,
  input  logic [AXI_DATA_BITS-1:0] res,
  input  logic                     res_vld
);

  // Decode works on word addresses; the two byte-offset bits are ignored.
  localparam int unsigned WordBits = AXI_ADDR_BITS - 2;
  localparam logic [WordBits-1:0] WordCtrl   = WordBits'(0);
  localparam logic [WordBits-1:0] WordArgA   = WordBits'(4);
  localparam logic [WordBits-1:0] WordArgB   = WordBits'(6);
  localparam logic [WordBits-1:0] WordResult = WordBits'(8);

  localparam logic [1:0] WAddr = 2'd0;
  localparam logic [1:0] WData = 2'd1;
  localparam logic [1:0] WResp = 2'd2;

  localparam logic RAddr = 1'b0;
  localparam logic RData = 1'b1;

  logic [1:0]               wstate_q, wstate_d;
  logic [WordBits-1:0]      waddr_q, waddr_d;
  logic                     rstate_q, rstate_d;
  logic [AXI_DATA_BITS-1:0] rdata_q, rdata_d;
  logic                     start_q, start_d;
  logic                     auto_q, auto_d;
  logic                     done_q, done_d;
  logic [AXI_DATA_BITS-1:0] arg_a_q, arg_a_d;
  logic [AXI_DATA_BITS-1:0] arg_b_q, arg_b_d;
  logic [AXI_DATA_BITS-1:0] result_q, result_d;

  logic                     w_commit;
  logic                     wr_ctrl;
  logic                     ar_hs;
  logic [WordBits-1:0]      rd_word;
  logic [AXI_DATA_BITS-1:0] rd_mux;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^{s_axi_control_AWADDR[1:0], s_axi_control_ARADDR[1:0]};

  // Write channel FSM: address, then data (commit), then response.
  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    w_commit = 1'b0;
    case (wstate_q)
      WAddr: begin
        if (s_axi_control_AWVALID) begin
          waddr_d  = s_axi_control_AWADDR[AXI_ADDR_BITS-1:2];
          wstate_d = WData;
        end
      end
      WData: begin
        if (s_axi_control_WVALID) begin
          w_commit = 1'b1;
          wstate_d = WResp;
        end
      end
      WResp: begin
        if (s_axi_control_BREADY) wstate_d = WAddr;
      end
      default: wstate_d = WAddr;
    endcase
  end

  assign s_axi_control_AWREADY = (wstate_q == WAddr);
  assign s_axi_control_WREADY  = (wstate_q == WData);
  assign s_axi_control_BVALID  = (wstate_q == WResp);
  assign s_axi_control_BRESP   = 2'b00;

  assign ar_hs   = (rstate_q == RAddr) && s_axi_control_ARVALID;
  assign rd_word = s_axi_control_ARADDR[AXI_ADDR_BITS-1:2];

  // Read data mux; the done bit includes a same-cycle ap_done so it is never lost to a clear.
  always_comb begin
    rd_mux = '0;
    case (rd_word)
      WordCtrl: begin
        rd_mux[0] = start_q;
        rd_mux[1] = done_q | ap_done;
        rd_mux[2] = ap_idle;
        rd_mux[3] = ap_ready;
        rd_mux[7] = auto_q;
      end
      WordArgA:   rd_mux = arg_a_q;
      WordArgB:   rd_mux = arg_b_q;
      WordResult: rd_mux = result_q;
      default:    rd_mux = '0;
    endcase
  end

  // Read channel FSM: capture data on AR handshake, hold it until RREADY.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    case (rstate_q)
      RAddr: begin
        if (s_axi_control_ARVALID) begin
          rdata_d  = rd_mux;
          rstate_d = RData;
        end
      end
      RData: begin
        if (s_axi_control_RREADY) rstate_d = RAddr;
      end
      default: rstate_d = RAddr;
    endcase
  end

  assign s_axi_control_ARREADY = (rstate_q == RAddr);
  assign s_axi_control_RVALID  = (rstate_q == RData);
  assign s_axi_control_RDATA   = rdata_q;
  assign s_axi_control_RRESP   = 2'b00;

  // Register file next-state: byte-strobed operands, control bits, sticky done, result.
  always_comb begin
    arg_a_d  = arg_a_q;
    arg_b_d  = arg_b_q;
    wr_ctrl  = w_commit && (waddr_q == WordCtrl) && s_axi_control_WSTRB[0];
    for (int unsigned b = 0; b < AXI_STRB_BITS; b++) begin
      if (w_commit && s_axi_control_WSTRB[b]) begin
        if (waddr_q == WordArgA) arg_a_d[b*8 +: 8] = s_axi_control_WDATA[b*8 +: 8];
        if (waddr_q == WordArgB) arg_b_d[b*8 +: 8] = s_axi_control_WDATA[b*8 +: 8];
      end
    end

    auto_d = wr_ctrl ? s_axi_control_WDATA[7] : auto_q;

    // A host set beats a core-ready clear in the same cycle.
    start_d = start_q;
    if (ap_ready && !auto_q) start_d = 1'b0;
    if (wr_ctrl && s_axi_control_WDATA[0]) start_d = 1'b1;

    done_d = done_q;
    if (ar_hs && (rd_word == WordCtrl)) done_d = 1'b0;
    if (ap_done) done_d = 1'b1;

    result_d = res_vld ? res : result_q;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wstate_q <= WAddr;
      waddr_q  <= '0;
      rstate_q <= RAddr;
      rdata_q  <= '0;
      start_q  <= 1'b0;
      auto_q   <= 1'b0;
      done_q   <= 1'b0;
      arg_a_q  <= '0;
      arg_b_q  <= '0;
      result_q <= '0;
    end else begin
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      start_q  <= start_d;
      auto_q   <= auto_d;
      done_q   <= done_d;
      arg_a_q  <= arg_a_d;
      arg_b_q  <= arg_b_d;
      result_q <= result_d;
    end
  end

  assign ap_start = start_q;
  assign arg_a    = arg_a_q;
  assign arg_b    = arg_b_q;

endmodule

// File: tb/tb_adder_ctrl_slave.sv
// Directed bench for adder_ctrl_slave: transaction-level register model plus literal checks.
module tb_adder_ctrl_slave;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic [5:0]  awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        ap_start_o;
  logic        ap_ready_i = 1'b0, ap_done_i = 1'b0, ap_idle_i = 1'b0, res_vld_i = 1'b0;
  logic [31:0] res_i = '0;
  logic [31:0] arg_a_o, arg_b_o;

  // Register-map model, updated only by the stimulus process.
  logic [31:0] m_arg_a = '0, m_arg_b = '0, m_result = '0;
  logic        m_start = 1'b0, m_auto = 1'b0, m_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  adder_ctrl_slave dut (
    .clock                 (clock),
    .reset                 (reset),
    .s_axi_control_AWVALID (awvalid),
    .s_axi_control_AWREADY (awready),
    .s_axi_control_AWADDR  (awaddr),
    .s_axi_control_WVALID  (wvalid),
    .s_axi_control_WREADY  (wready),
    .s_axi_control_WDATA   (wdata),
    .s_axi_control_WSTRB   (wstrb),
    .s_axi_control_BVALID  (bvalid),
    .s_axi_control_BREADY  (bready),
    .s_axi_control_BRESP   (bresp),
    .s_axi_control_ARVALID (arvalid),
    .s_axi_control_ARREADY (arready),
    .s_axi_control_ARADDR  (araddr),
    .s_axi_control_RVALID  (rvalid),
    .s_axi_control_RREADY  (rready),
    .s_axi_control_RDATA   (rdata),
    .s_axi_control_RRESP   (rresp),
    .ap_start              (ap_start_o),
    .ap_ready              (ap_ready_i),
    .ap_done               (ap_done_i),
    .ap_idle               (ap_idle_i),
    .arg_a                 (arg_a_o),
    .arg_b                 (arg_b_o),
    .res                   (res_i),
    .res_vld               (res_vld_i)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] addr, input logic done_now);
    logic [31:0] v;
    v = '0;
    case (addr[5:2])
      4'h0: begin
        v[0] = m_start;
        v[1] = m_done | done_now;
        v[2] = ap_idle_i;
        v[3] = ap_ready_i;
        v[7] = m_auto;
      end
      4'h4:    v = m_arg_a;
      4'h6:    v = m_arg_b;
      4'h8:    v = m_result;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_arg_a = '0; m_arg_b = '0; m_result = '0;
    m_start = 1'b0; m_auto = 1'b0; m_done = 1'b0;
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int bhold);
    int n;
    awaddr = addr; awvalid = 1'b1; bready = (bhold == 0);
    n = 0;
    @(negedge clock);
    while (!awready && n < 20) begin n++; @(negedge clock); end
    check("awready", awready, 1);
    @(posedge clock); #1;
    awvalid = 1'b0; wvalid = 1'b1; wdata = data; wstrb = strb;
    @(negedge clock);
    check("wready", wready, 1);
    check("awready_in_wdata", awready, 0);
    @(posedge clock);
    case (addr[5:2])
      4'h0: if (strb[0]) begin m_auto = data[7]; if (data[0]) m_start = 1'b1; end
      4'h4: for (int b = 0; b < 4; b++) if (strb[b]) m_arg_a[b*8 +: 8] = data[b*8 +: 8];
      4'h6: for (int b = 0; b < 4; b++) if (strb[b]) m_arg_b[b*8 +: 8] = data[b*8 +: 8];
      default: ;
    endcase
    #1 wvalid = 1'b0;
    for (int i = 0; i < bhold; i++) begin
      @(negedge clock);
      check("bvalid_held", bvalid, 1);
      check("awready_while_bvalid", awready, 0);
      @(posedge clock); #1;
    end
    bready = 1'b1;
    @(negedge clock);
    check("bvalid", bvalid, 1);
    check("bresp", bresp, 0);
    @(posedge clock); #1;
  endtask

  task automatic axi_read(input logic [5:0] addr, input bit done_with_ar,
                          input bit use_lit, input logic [31:0] lit);
    int n;
    logic [31:0] exp;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    if (done_with_ar) ap_done_i = 1'b1;
    n = 0;
    @(negedge clock);
    while (!arready && n < 20) begin n++; @(negedge clock); end
    check("arready", arready, 1);
    exp = model_read(addr, done_with_ar);
    @(posedge clock);
    if (done_with_ar) m_done = 1'b1;
    else if (addr[5:2] == 4'h0) m_done = 1'b0;
    #1 arvalid = 1'b0; ap_done_i = 1'b0;
    @(negedge clock);
    check("rvalid", rvalid, 1);
    check("rdata_model", rdata, exp);
    if (use_lit) check("rdata_literal", rdata, lit);
    @(posedge clock); #1;
  endtask

  task automatic pulse(input bit rdy, input bit done, input bit rv, input logic [31:0] r);
    ap_ready_i = rdy; ap_done_i = done; res_vld_i = rv; res_i = r;
    @(posedge clock);
    if (done) m_done = 1'b1;
    if (rv) m_result = r;
    if (rdy && !m_auto) m_start = 1'b0;
    #1 ap_ready_i = 1'b0; ap_done_i = 1'b0; res_vld_i = 1'b0;
  endtask

  // Continuous comparison of the register-backed outputs against the model.
  always @(negedge clock) begin
    if (!reset) begin
      check("arg_a", arg_a_o, m_arg_a);
      check("arg_b", arg_b_o, m_arg_b);
      check("ap_start", {31'b0, ap_start_o}, {31'b0, m_start});
      check("bresp_const", {30'b0, bresp}, 32'd0);
      check("rresp_const", {30'b0, rresp}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    // Reset state.
    reset = 1'b1;
    repeat (3) @(posedge clock);
    model_reset();
    @(negedge clock);
    check("rst_awready", awready, 1);
    check("rst_arready", arready, 1);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ap_start", ap_start_o, 0);
    check("rst_arg_a", arg_a_o, 0);
    check("rst_arg_b", arg_b_o, 0);
    @(posedge clock); #1 reset = 1'b0;

    // Operands.
    axi_write(6'h10, 32'h5, 4'hF, 0);
    axi_write(6'h18, 32'h7, 4'hF, 0);
    check("arg_a_lit", arg_a_o, 32'd5);
    check("arg_b_lit", arg_b_o, 32'd7);
    axi_read(6'h10, 0, 1, 32'd5);
    axi_read(6'h18, 0, 1, 32'd7);

    // Start, ready, result, done.
    axi_write(6'h00, 32'h1, 4'hF, 0);
    check("ap_start_set_lit", ap_start_o, 1);
    pulse(1, 0, 0, 0);
    @(negedge clock);
    check("ap_start_clr_lit", ap_start_o, 0);
    @(posedge clock); #1;
    pulse(0, 1, 1, 32'd12);
    axi_read(6'h20, 0, 1, 32'h0000000C);

    // Done is clear-on-read.
    ap_idle_i = 1'b1;
    axi_read(6'h00, 0, 1, 32'h6);
    axi_read(6'h00, 0, 1, 32'h4);

    // ap_done coinciding with the clearing read survives.
    axi_read(6'h00, 1, 1, 32'h6);
    axi_read(6'h00, 0, 1, 32'h6);

    // Byte strobes, read-only RESULT, unmapped read, ignored offset bits.
    axi_write(6'h10, 32'hAABBCCDD, 4'hF, 0);
    axi_write(6'h10, 32'h11223344, 4'h5, 0);
    check("arg_a_strb_lit", arg_a_o, 32'hAA22CC44);
    axi_write(6'h20, 32'hFFFFFFFF, 4'hF, 0);
    axi_read(6'h20, 0, 1, 32'h0000000C);
    axi_read(6'h3C, 0, 1, 32'h0);
    axi_read(6'h13, 0, 1, 32'hAA22CC44);

    // auto_restart keeps ap_start asserted across ap_ready; a write of 0 does not clear it.
    axi_write(6'h00, 32'h81, 4'hF, 0);
    axi_read(6'h00, 0, 1, 32'h85);
    pulse(1, 0, 0, 0);
    axi_write(6'h00, 32'h0, 4'hF, 0);
    check("ap_start_auto_lit", ap_start_o, 1);
    pulse(1, 0, 0, 0);
    @(negedge clock);
    check("ap_start_after_auto_lit", ap_start_o, 0);
    @(posedge clock); #1;

    // Back-pressured write response.
    axi_write(6'h18, 32'h0000BEEF, 4'h3, 5);
    check("arg_b_bp_lit", arg_b_o, 32'h0000BEEF);

    // Reset while a read response is pending.
    araddr = 6'h10; arvalid = 1'b1; rready = 1'b0;
    @(negedge clock);
    check("arready_pre_rst", arready, 1);
    @(posedge clock); #1 arvalid = 1'b0;
    @(negedge clock);
    check("rvalid_pre_rst", rvalid, 1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock);
    model_reset();
    @(negedge clock);
    check("rvalid_after_rst", rvalid, 0);
    check("arready_after_rst", arready, 1);
    @(posedge clock); #1 reset = 1'b0; rready = 1'b1;
    axi_read(6'h10, 0, 1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_ctrl_slave.md
Name: adder_ctrl_slave

Overview:
AXI4-Lite control slave that terminates the s_axi_control bus driven by the host bridge and exposes the adder accelerator's block-level handshake and argument registers. It is the stage directly downstream of the host bridge, between that bridge and the adder compute core. It implements an ap_ctrl_hs-style register file: start, done, idle and ready bits; two operand registers; and one captured result register.

Parameters:
AXI_ADDR_BITS, 6, s_axi_control address width (byte addresses)
AXI_DATA_BITS, 32, s_axi_control data width; also operand and result width
AXI_STRB_BITS, AXI_DATA_BITS/8, write-strobe width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
s_axi_control_AWVALID  in  1  write address valid
s_axi_control_AWREADY  out  1  write address ready
s_axi_control_AWADDR  in  AXI_ADDR_BITS  write address
s_axi_control_WVALID  in  1  write data valid
s_axi_control_WREADY  out  1  write data ready
s_axi_control_WDATA  in  AXI_DATA_BITS  write data
s_axi_control_WSTRB  in  AXI_STRB_BITS  byte strobes
s_axi_control_BVALID  out  1  write response valid
s_axi_control_BREADY  in  1  write response ready
s_axi_control_BRESP  out  2  always 2'b00 (OKAY)
s_axi_control_ARVALID  in  1  read address valid
s_axi_control_ARREADY  out  1  read address ready
s_axi_control_ARADDR  in  AXI_ADDR_BITS  read address
s_axi_control_RVALID  out  1  read data valid
s_axi_control_RREADY  in  1  read data ready
s_axi_control_RDATA  out  AXI_DATA_BITS  read data
s_axi_control_RRESP  out  2  always 2'b00
ap_start  out  1  start request to core
ap_ready  in  1  core accepted inputs (1-cycle pulse)
ap_done  in  1  core finished (1-cycle pulse)
ap_idle  in  1  core idle level
arg_a  out  AXI_DATA_BITS  operand A
arg_b  out  AXI_DATA_BITS  operand B
res  in  AXI_DATA_BITS  result from core
res_vld  in  1  res valid this cycle

Behaviour:
Register map (byte address):
- 0x00 CTRL:
  - bit0 ap_start: RW; a write of 1 sets it; a write of 0 is ignored.
  - bit1 ap_done: RO; sticky; clear-on-read.
  - bit2 ap_idle: RO; live.
  - bit3 ap_ready: RO; live.
  - bit7 auto_restart: RW.
  - All other bits read 0.
- 0x10 ARG_A: RW, byte-strobed.
- 0x18 ARG_B: RW, byte-strobed.
- 0x20 RESULT: RO.
- Unmapped reads return 0. Unmapped writes and writes to RO fields are ignored, but still get an OKAY response.

Write FSM (W_ADDR -> W_DATA -> W_RESP):
- W_ADDR: AWREADY=1. On AWVALID, latch AWADDR and go to W_DATA.
- W_DATA: WREADY=1. On WVALID, commit the write for bytes with WSTRB set, then go to W_RESP.
- W_RESP: BVALID=1. On BREADY, return to W_ADDR.
- Minimum of 3 cycles per write. No outstanding-transaction overlap.

Read FSM (R_ADDR -> R_DATA):
- R_ADDR: ARREADY=1. On ARVALID, register the addressed value into RDATA and go to R_DATA.
- R_DATA: RVALID=1, RDATA is held stable. On RREADY, return to R_ADDR.
- Read latency is 1 cycle from the AR handshake to RVALID.
- The read and write FSMs are independent and may run concurrently. A read whose AR handshake coincides with a W commit to the same register returns the old value.

ap_start:
- Set on a CTRL write with WSTRB[0]=1 and WDATA[0]=1.
- Cleared in the cycle after ap_ready=1 when auto_restart=0. It stays 1 when auto_restart=1.
- If a set and an ap_ready-clear occur in the same cycle, set wins.

ap_done sticky bit:
- Set on ap_done=1.
- Cleared on the AR handshake of address 0x00, after that read has captured the bit as 1.
- If ap_done pulses in the same cycle as the clearing read, the bit remains 1.

RESULT captures res on res_vld=1 and holds it otherwise.

arg_a and arg_b drive the ARG_A and ARG_B registers directly.

Reset values:
- AWREADY=1, ARREADY=1.
- WREADY=0, BVALID=0, RVALID=0, RDATA=0, BRESP=0, RRESP=0.
- ap_start=0, auto_restart=0, done sticky=0.
- ARG_A=0, ARG_B=0, RESULT=0.
- A reset mid-transaction aborts it. Any pending B or R response is dropped, and a partially addressed write is not committed.

Address decode uses only ARADDR/AWADDR[AXI_ADDR_BITS-1:2]. Bits [1:0] are ignored.

Test Plan:
- Write 0x10=0x00000005, then 0x18=0x00000007, with WSTRB=0xF -> each write gets BVALID with BRESP=0; arg_a=5, arg_b=7; reading back 0x10 and 0x18 returns 5 and 7.
- Write 0x00=0x1 -> ap_start=1 on the cycle after the W handshake. Pulse ap_ready -> ap_start=0 the next cycle. Pulse res_vld with res=12 and ap_done -> a read of 0x20 returns 0x0C.
- After ap_done, read 0x00 twice with ap_idle=1 -> first RDATA=0x6, second RDATA=0x4.
- Apply ap_done on the same cycle as the AR handshake for 0x00 -> that read returns bit1=1, and the next read also returns bit1=1.
- Write 0x10=0xAABBCCDD with WSTRB=0xF, then 0x10=0x11223344 with WSTRB=0x5 -> arg_a=0xAA22CC44. A write to 0x20 leaves RESULT unchanged with BRESP=0. A read of 0x3C returns 0.
- Hold BREADY=0 for 5 cycles -> BVALID stays 1 and AWREADY=0 throughout. Assert reset while RVALID=1 -> next cycle RVALID=0 and ARREADY=1.
